// File: rtl/pc_gen_pkg.sv
// Shared encodings for the next-PC generator: pc_src codes and redirect priority ranks.
package pc_gen_pkg;

    localparam int unsigned PCS_W  = 3;
    localparam int unsigned RANK_W = 2;

    localparam logic [PCS_W-1:0] PCS_HOLD = 3'b000;
    localparam logic [PCS_W-1:0] PCS_SEQ  = 3'b001;
    localparam logic [PCS_W-1:0] PCS_BR   = 3'b010;
    localparam logic [PCS_W-1:0] PCS_JMP  = 3'b011;
    localparam logic [PCS_W-1:0] PCS_EXC  = 3'b100;
    localparam logic [PCS_W-1:0] PCS_INT  = 3'b101;
    localparam logic [PCS_W-1:0] PCS_ERET = 3'b110;
    localparam logic [PCS_W-1:0] PCS_RAS  = 3'b111;

    // INT outranks EXC, which outranks every other redirect.
    function automatic logic [RANK_W-1:0] pcs_rank(input logic [PCS_W-1:0] src);
        case (src)
            PCS_INT: return RANK_W'(2);
            PCS_EXC: return RANK_W'(1);
            default: return RANK_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned AW        = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_push_data,
    output logic [AW-1:0] o_top,
    output logic          o_empty
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_pop;

    assign o_empty = (r_cnt == CW'(0));
    assign w_full  = (r_cnt == CW'(RAS_DEPTH));
    assign o_top   = r_mem[r_top];
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_top <= PW'(0);
            r_cnt <= CW'(0);
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_mem[i] <= AW'(0);
            end
        end else if (i_push && w_pop) begin
            // Simultaneous call and return: the new return address replaces the popped top.
            r_mem[r_top] <= i_push_data;
        end else if (i_push) begin
            r_top               <= r_top + PW'(1);
            r_mem[r_top + PW'(1)] <= i_push_data;
            if (!w_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_pop) begin
            r_top <= r_top - PW'(1);
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC register: priority target mux, one-entry stall-time redirect buffer and RAS prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180,
    parameter logic [31:0] INT_VEC   = 32'h8000_0200,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [PCS_W-1:0] pc_src,
    input  logic [AW-3:0]    br_tgt,
    input  logic [AW-3:0]    j_tgt,
    input  logic [AW-1:0]    epc,
    input  logic             ras_push,
    output logic [AW-1:0]    pc_out,
    output logic             redir_pend,
    output logic             ras_empty,
    output logic             ras_miss
);

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
    localparam logic [AW-1:0] RST_PC     = AW'(RESET_VEC) & ALIGN_MASK;

    logic [AW-1:0]     r_pc;
    logic              r_pend;
    logic [AW-1:0]     r_pend_pc;
    logic [RANK_W-1:0] r_pend_rank;
    logic              r_miss;
    logic              r_first;

    logic [AW-1:0]     w_seq;
    logic [AW-1:0]     w_ras_top;
    logic              w_ras_empty;
    logic [AW-1:0]     w_tgt;
    logic              w_stall;
    logic              w_is_redir;
    logic              w_is_trap;
    logic              w_pop;
    logic [AW-1:0]     w_pc_nxt;
    logic              w_pend_nxt;
    logic [AW-1:0]     w_pend_pc_nxt;
    logic [RANK_W-1:0] w_pend_rank_nxt;

    assign w_seq      = r_pc + AW'(4);
    assign w_stall    = stall & ~r_first;
    assign w_is_redir = (pc_src >= PCS_BR);
    assign w_is_trap  = (pc_src == PCS_EXC) || (pc_src == PCS_INT);

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .AW        (AW)
    ) u_ras (
        .i_clk       (Clk),
        .i_rst_n     (reset),
        .i_push      (ras_push),
        .i_pop       (w_pop),
        .i_push_data (w_seq),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

    // Resolved target of the current pc_src; an empty RAS falls back to sequential.
    always_comb begin
        w_tgt = r_pc;
        case (pc_src)
            PCS_HOLD: w_tgt = r_pc;
            PCS_SEQ:  w_tgt = w_seq;
            PCS_BR:   w_tgt = {br_tgt, 2'b00};
            PCS_JMP:  w_tgt = {j_tgt, 2'b00};
            PCS_EXC:  w_tgt = AW'(EXC_VEC) & ALIGN_MASK;
            PCS_INT:  w_tgt = AW'(INT_VEC) & ALIGN_MASK;
            PCS_ERET: w_tgt = epc & ALIGN_MASK;
            PCS_RAS:  w_tgt = w_ras_empty ? w_seq : w_ras_top;
            default:  w_tgt = r_pc;
        endcase
    end

    // Under stall capture redirects; otherwise traps beat the buffered redirect, which beats pc_src.
    always_comb begin
        w_pc_nxt        = r_pc;
        w_pend_nxt      = r_pend;
        w_pend_pc_nxt   = r_pend_pc;
        w_pend_rank_nxt = r_pend_rank;
        w_pop           = 1'b0;
        if (w_stall) begin
            if (w_is_redir && (!r_pend || (pcs_rank(pc_src) >= r_pend_rank))) begin
                w_pend_nxt      = 1'b1;
                w_pend_pc_nxt   = w_tgt;
                w_pend_rank_nxt = pcs_rank(pc_src);
                w_pop           = (pc_src == PCS_RAS);
            end
        end else if (w_is_trap) begin
            w_pc_nxt   = w_tgt;
            w_pend_nxt = 1'b0;
        end else if (r_pend) begin
            w_pc_nxt   = r_pend_pc;
            w_pend_nxt = 1'b0;
        end else begin
            w_pc_nxt = w_tgt;
            w_pop    = (pc_src == PCS_RAS);
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RST_PC;
            r_pend      <= 1'b0;
            r_pend_pc   <= AW'(0);
            r_pend_rank <= RANK_W'(0);
            r_miss      <= 1'b0;
            r_first     <= 1'b1;
        end else begin
            r_pc        <= w_pc_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_pend_rank <= w_pend_rank_nxt;
            r_miss      <= w_pop & w_ras_empty;
            r_first     <= 1'b0;
        end
    end

    assign pc_out     = r_pc;
    assign redir_pend = r_pend;
    assign ras_miss   = r_miss;
    assign ras_empty  = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequencing, stall buffering, priority, wrap, ERET and RAS.
module tb_pc_gen;

    logic        Clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic [29:0] br_tgt;
    logic [29:0] j_tgt;
    logic [31:0] epc;
    logic        ras_push;
    logic [31:0] pc_out;
    logic        redir_pend;
    logic        ras_empty;
    logic        ras_miss;

    int n_vec = 0;
    int n_err = 0;

    pc_gen dut (
        .Clk        (Clk),
        .reset      (reset),
        .stall      (stall),
        .pc_src     (pc_src),
        .br_tgt     (br_tgt),
        .j_tgt      (j_tgt),
        .epc        (epc),
        .ras_push   (ras_push),
        .pc_out     (pc_out),
        .redir_pend (redir_pend),
        .ras_empty  (ras_empty),
        .ras_miss   (ras_miss)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; pc_src = 3'b000; br_tgt = '0; j_tgt = '0;
        epc = '0; ras_push = 1'b0;
        #12;
        check("rst_pc", pc_out, 32'hBFC0_0000);
        check("rst_pend", 32'(redir_pend), 32'd0);
        check("rst_miss", 32'(ras_miss), 32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        reset = 1'b1;
        pc_src = 3'b001;
        cyc(); check("seq0", pc_out, 32'hBFC0_0004);
        cyc(); check("seq1", pc_out, 32'hBFC0_0008);

        // Mid-run reset, released while stalled.
        #2 reset = 1'b0; stall = 1'b1;
        #1 check("midrst_pc", pc_out, 32'hBFC0_0000);
        @(negedge Clk); reset = 1'b1;
        cyc(); check("seq_after_rst_stall", pc_out, 32'hBFC0_0004);
        stall = 1'b0;
        cyc(); check("seq_a", pc_out, 32'hBFC0_0008);
        cyc(); check("seq_b", pc_out, 32'hBFC0_000C);

        // Branch captured during stall, applied at release.
        stall = 1'b1; pc_src = 3'b010; br_tgt = 30'h2F00_0010;
        cyc(); check("stall_hold", pc_out, 32'hBFC0_000C);
        check("stall_pend", 32'(redir_pend), 32'd1);
        stall = 1'b0; pc_src = 3'b000;
        cyc(); check("br_release", pc_out, 32'hBC00_0040);
        check("br_pend_clr", 32'(redir_pend), 32'd0);

        // INT overrides buffered branch; a later branch cannot displace INT.
        stall = 1'b1; pc_src = 3'b010; br_tgt = 30'h0000_0100;
        cyc();
        pc_src = 3'b101;
        cyc();
        pc_src = 3'b010; br_tgt = 30'h0000_0200;
        cyc(); check("int_hold", pc_out, 32'hBC00_0040);
        check("int_pend", 32'(redir_pend), 32'd1);
        stall = 1'b0; pc_src = 3'b001;
        cyc(); check("int_release", pc_out, 32'h8000_0200);
        check("int_pend_clr", 32'(redir_pend), 32'd0);

        // Sequential wrap and ERET alignment.
        pc_src = 3'b011; j_tgt = 30'h3FFF_FFFF;
        cyc(); check("jmp_top", pc_out, 32'hFFFF_FFFC);
        pc_src = 3'b001;
        cyc(); check("wrap", pc_out, 32'h0000_0000);
        pc_src = 3'b110; epc = 32'h8000_1237;
        cyc(); check("eret", pc_out, 32'h8000_1234);

        // RAS overflow then underflow.
        pc_src = 3'b011; j_tgt = 30'h40;
        cyc(); check("jmp_100", pc_out, 32'h0000_0100);
        for (int k = 1; k <= 4; k++) begin
            ras_push = 1'b1; j_tgt = 30'((k + 1) * 32'h40);
            cyc();
        end
        check("jmp_500", pc_out, 32'h0000_0500);
        ras_push = 1'b1; pc_src = 3'b000;
        cyc();
        ras_push = 1'b0;
        check("ras_nonempty", 32'(ras_empty), 32'd0);
        pc_src = 3'b111;
        cyc(); check("pop0", pc_out, 32'h0000_0504);
        cyc(); check("pop1", pc_out, 32'h0000_0404);
        cyc(); check("pop2", pc_out, 32'h0000_0304);
        cyc(); check("pop3", pc_out, 32'h0000_0204);
        check("ras_empty_after", 32'(ras_empty), 32'd1);
        check("no_miss_yet", 32'(ras_miss), 32'd0);
        cyc(); check("pop_miss_pc", pc_out, 32'h0000_0208);
        check("pop_miss", 32'(ras_miss), 32'd1);
        check("miss_empty", 32'(ras_empty), 32'd1);
        pc_src = 3'b000;
        cyc(); check("miss_pulse_end", 32'(ras_miss), 32'd0);

        // Push and pop in one cycle.
        pc_src = 3'b011; j_tgt = 30'h400;
        cyc(); check("jmp_1000", pc_out, 32'h0000_1000);
        ras_push = 1'b1; j_tgt = 30'hC00;
        cyc(); check("jmp_3000", pc_out, 32'h0000_3000);
        pc_src = 3'b111;
        cyc(); check("pushpop", pc_out, 32'h0000_1004);
        check("pushpop_nonempty", 32'(ras_empty), 32'd0);
        ras_push = 1'b0;
        cyc(); check("pop_after_pp", pc_out, 32'h0000_3004);
        check("pp_empty", 32'(ras_empty), 32'd1);
        check("pp_no_miss", 32'(ras_miss), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
